// File: rtl/multicycle_control_fsm.sv
// Main controller for the multicycle RV32I datapath (lw, sw, R-type, I-type, beq).
// Latency: Moore outputs decoded from the state register; PCWrite/ImmSrc/ALUControl also see inputs.
// Backpressure: none; one state per cycle, reset aborts the current instruction.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   op, funct3, funct7b5  instruction fields from the IR (stable DECODE..next FETCH)
//   Zero                  ALU zero flag, consulted only in BEQ
//   PCWrite .. ImmSrc     datapath enables and mux selects
//   IllegalInstr          sticky illegal-opcode flag
//
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN
//   defined   - undefined opcode traps into HALT (all enables 0, IllegalInstr=1) until reset
//   undefined - undefined opcode returns to FETCH as a 2-cycle NOP, IllegalInstr tied 0

module multicycle_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       IllegalInstr
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BEQ
`ifdef CTRL_ILLEGAL_TRAP_EN
        ,
        S_HALT
`endif
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_FUNCT
    } alu_op_t;

    state_t  state_q, state_d;
    alu_op_t alu_op;
    logic    branch;
    logic    pc_update;

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d = S_FETCH;
        unique case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                unique case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:      state_d = S_HALT;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            // op[5] separates sw (1) from lw (0) once DECODE has routed here
            S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_HALT:     state_d = S_HALT;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    // ---------------------------------------------------------------
    // Moore outputs per state; reset forces FETCH selects with all
    // write enables cleared so an aborted instruction commits nothing.
    // ---------------------------------------------------------------
    always_comb begin
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        alu_op    = ALU_ADD;
        branch    = 1'b0;
        pc_update = 1'b0;

        if (reset) begin
            ResultSrc = 2'b10;
            ALUSrcB   = 2'b10;
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    IRWrite   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    pc_update = 1'b1;
                end
                S_DECODE: begin
                    // Branch target OldPC + ImmExt lands in ALUOut for BEQ
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                end
                S_MEMADR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                end
                S_MEMREAD: begin
                    AdrSrc = 1'b1;
                end
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = 1'b1;
                end
                S_MEMWRITE: begin
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                end
                S_EXECUTER: begin
                    ALUSrcA = 2'b10;
                    alu_op  = ALU_FUNCT;
                end
                S_EXECUTEI: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    alu_op  = ALU_FUNCT;
                end
                S_ALUWB: begin
                    RegWrite = 1'b1;
                end
                S_BEQ: begin
                    ALUSrcA = 2'b10;
                    alu_op  = ALU_SUB;
                    branch  = 1'b1;
                end
                default: begin
                    // HALT: everything stays at zero
                end
            endcase
        end
    end

    assign PCWrite = (branch & Zero) | pc_update;

    // ---------------------------------------------------------------
    // Immediate format select, decoded from op in every state
    // ---------------------------------------------------------------
    always_comb begin
        ImmSrc = 2'b00;
        unique case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            default: ImmSrc = 2'b00;
        endcase
    end

    // ---------------------------------------------------------------
    // ALU decode
    // ---------------------------------------------------------------
    always_comb begin
        ALUControl = 3'b000;
        unique case (alu_op)
            ALU_SUB:   ALUControl = 3'b001;
            ALU_FUNCT: begin
                unique case (funct3)
                    // funct7b5 only means sub for R-type; for addi it is an immediate bit
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default:   ALUControl = 3'b000;
        endcase
    end

    // ---------------------------------------------------------------
    // Illegal-opcode flag: HALT is only left through reset, so the
    // state itself is the sticky bit.
    // ---------------------------------------------------------------
`ifdef CTRL_ILLEGAL_TRAP_EN
    assign IllegalInstr = (state_q == S_HALT) & ~reset;
`else
    assign IllegalInstr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm.
// Stimulus drives one cycle at a time and queues the hand-written expected output vector;
// a monitor pops and compares on every falling edge.

module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalInstr;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    multicycle_control_fsm dut (
        .clk          (clk),
        .reset        (reset),
        .op           (op),
        .funct3       (funct3),
        .funct7b5     (funct7b5),
        .Zero         (Zero),
        .PCWrite      (PCWrite),
        .AdrSrc       (AdrSrc),
        .MemWrite     (MemWrite),
        .IRWrite      (IRWrite),
        .RegWrite     (RegWrite),
        .ResultSrc    (ResultSrc),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .ALUControl   (ALUControl),
        .ImmSrc       (ImmSrc),
        .IllegalInstr (IllegalInstr)
    );

    always #5 clk = ~clk;

    // {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, IllegalInstr}
    logic [16:0] act;
    assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ALUControl, ImmSrc, IllegalInstr};

    logic [16:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    function automatic logic [16:0] v(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic rw, input logic [1:0] res,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [2:0] alu, input logic [1:0] imm,
                                      input logic ill);
        return {pcw, adr, mw, irw, rw, res, sa, sb, alu, imm, ill};
    endfunction

    task automatic cyc(input logic r, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic z, input logic [16:0] e, input string nm);
        @(posedge clk);
        #1;
        reset    = r;
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
        Zero     = z;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: outputs are valid every cycle, so compare each queued entry mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [16:0] e;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %b required %b", nm, act, e);
            end
        end
    end

    initial begin
        reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0;

        // Reset held two cycles: FETCH selects, enables off
        cyc(1, 7'd0, 3'b000, 0, 0, v(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), "rst_c1");
        cyc(1, 7'd0, 3'b000, 0, 0, v(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), "rst_c2");

        // lw: 5 cycles
        cyc(0, LW, 3'b010, 0, 0, v(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), "lw_fetch");
        cyc(0, LW, 3'b010, 0, 0, v(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0), "lw_decode");
        cyc(0, LW, 3'b010, 0, 0, v(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0), "lw_memadr");
        cyc(0, LW, 3'b010, 0, 0, v(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0), "lw_memread");
        cyc(0, LW, 3'b010, 0, 0, v(0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,2'b00,0), "lw_memwb");

        // sw: 4 cycles, S immediate
        cyc(0, SW, 3'b010, 0, 0, v(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b01,0), "sw_fetch");
        cyc(0, SW, 3'b010, 0, 0, v(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b01,0), "sw_decode");
        cyc(0, SW, 3'b010, 0, 0, v(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b01,0), "sw_memadr");
        cyc(0, SW, 3'b010, 0, 0, v(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b01,0), "sw_memwrite");

        // R-type sub (funct3 000, funct7b5 1)
        cyc(0, RT, 3'b000, 1, 0, v(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), "sub_fetch");
        cyc(0, RT, 3'b000, 1, 0, v(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0), "sub_decode");
        cyc(0, RT, 3'b000, 1, 0, v(0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b00,0), "sub_exec");
        cyc(0, RT, 3'b000, 1, 0, v(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,0), "sub_aluwb");

        // R-type and (funct3 111)
        cyc(0, RT, 3'b111, 0, 0, v(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), "and_fetch");
        cyc(0, RT, 3'b111, 0, 0, v(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0), "and_decode");
        cyc(0, RT, 3'b111, 0, 0, v(0,0,0,0,0,2'b00,2'b10,2'b00,3'b010,2'b00,0), "and_exec");
        cyc(0, RT, 3'b111, 0, 0, v(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,0), "and_aluwb");

        // R-type or (funct3 110), exec only shown after fetch/decode
        cyc(0, RT, 3'b110, 0, 0, v(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), "or_fetch");
        cyc(0, RT, 3'b110, 0, 0, v(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0), "or_decode");
        cyc(0, RT, 3'b110, 0, 0, v(0,0,0,0,0,2'b00,2'b10,2'b00,3'b011,2'b00,0), "or_exec");
        cyc(0, RT, 3'b110, 0, 0, v(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,0), "or_aluwb");

        // addi with imm bit 30 set: op[5]=0 so it must stay add
        cyc(0, IT, 3'b000, 1, 0, v(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), "addi_fetch");
        cyc(0, IT, 3'b000, 1, 0, v(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0), "addi_decode");
        cyc(0, IT, 3'b000, 1, 0, v(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0), "addi_exec");
        cyc(0, IT, 3'b000, 1, 0, v(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,0), "addi_aluwb");

        // slti
        cyc(0, IT, 3'b010, 0, 0, v(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), "slti_fetch");
        cyc(0, IT, 3'b010, 0, 0, v(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0), "slti_decode");
        cyc(0, IT, 3'b010, 0, 0, v(0,0,0,0,0,2'b00,2'b10,2'b01,3'b101,2'b00,0), "slti_exec");
        cyc(0, IT, 3'b010, 0, 0, v(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,0), "slti_aluwb");

        // beq taken: Zero high all along, only matters in BEQ
        cyc(0, BQ, 3'b000, 0, 1, v(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b10,0), "beqt_fetch");
        cyc(0, BQ, 3'b000, 0, 1, v(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b10,0), "beqt_decode");
        cyc(0, BQ, 3'b000, 0, 1, v(1,0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b10,0), "beqt_beq");

        // beq not taken
        cyc(0, BQ, 3'b000, 0, 0, v(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b10,0), "beqn_fetch");
        cyc(0, BQ, 3'b000, 0, 0, v(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b10,0), "beqn_decode");
        cyc(0, BQ, 3'b000, 0, 0, v(0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b10,0), "beqn_beq");

        // Reset mid-lw aborts; FETCH follows reset release
        cyc(0, LW, 3'b010, 0, 0, v(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), "abort_fetch");
        cyc(0, LW, 3'b010, 0, 0, v(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0), "abort_decode");
        cyc(1, LW, 3'b010, 0, 0, v(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), "abort_rst");
        cyc(0, SW, 3'b010, 0, 0, v(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b01,0), "abort_refetch");
        cyc(0, SW, 3'b010, 0, 0, v(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b01,0), "abort_decode2");
        cyc(0, SW, 3'b010, 0, 0, v(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b01,0), "abort_memadr");
        cyc(0, SW, 3'b010, 0, 0, v(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b01,0), "abort_memwrite");

        // Undefined opcode
        cyc(0, BAD, 3'b000, 0, 1, v(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), "bad_fetch");
        cyc(0, BAD, 3'b000, 0, 1, v(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0), "bad_decode");
`ifdef CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            cyc(0, BAD, 3'b000, 0, 1, v(0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1), "bad_halt");
        end
        cyc(1, BAD, 3'b000, 0, 1, v(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), "bad_rst");
        cyc(0, LW, 3'b010, 0, 0, v(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), "bad_refetch");
        cyc(0, LW, 3'b010, 0, 0, v(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0), "bad_redecode");
`else
        cyc(0, LW, 3'b010, 0, 0, v(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'b00,0), "bad_refetch");
        cyc(0, LW, 3'b010, 0, 0, v(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'b00,0), "bad_redecode");
        cyc(0, LW, 3'b010, 0, 0, v(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0), "bad_memadr");
`endif

        // Bounded drain of the scoreboard
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main controller for the multicycle RV32I datapath. Holds the instruction-sequencing state machine and drives every datapath enable and mux select. This includes `ImmSrc`, which feeds the immediate sign-extension unit directly. Supports lw, sw, R-type ALU ops, I-type ALU ops and beq. Immediate formats are limited to I, S and B, matching the 2-bit immediate selector.

## Interface
Parameters: none.

- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset.
- `op` in 7: opcode bits Instr[6:0], taken from the instruction register.
- `funct3` in 3: Instr[14:12].
- `funct7b5` in 1: Instr[30].
- `Zero` in 1: ALU zero flag.
- `PCWrite` out 1: PC register enable.
- `AdrSrc` out 1: memory address select (0 = PC, 1 = ALUOut).
- `MemWrite` out 1: data memory write enable.
- `IRWrite` out 1: enable for the instruction register and the OldPC register.
- `RegWrite` out 1: register file write enable.
- `ResultSrc` out 2: result select (00 = ALUOut, 01 = Data, 10 = ALUResult).
- `ALUSrcA` out 2: ALU A select (00 = PC, 01 = OldPC, 10 = rs1 register A).
- `ALUSrcB` out 2: ALU B select (00 = register B, 01 = ImmExt, 10 = constant 4).
- `ALUControl` out 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `ImmSrc` out 2: 00 = I-type, 01 = S-type, 10 = B-type.
- `IllegalInstr` out 1: sticky illegal-opcode flag; see Configuration.

## Operation
- Moore FSM with one state register. The only outputs that depend on inputs are `PCWrite` (uses `Zero`), and the decoded `ImmSrc` and `ALUControl`.
- States and their non-zero outputs. Every output not listed is 0.
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10, PCUpdate=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=add. This precomputes the branch target into ALUOut.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=add.
  - MEMREAD: ResultSrc=00, AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=funct.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=funct.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=sub, ResultSrc=00, Branch=1.
- Transitions:
  - FETCH → DECODE.
  - DECODE on 0000011 or 0100011 → MEMADR.
  - DECODE on 0110011 → EXECUTER.
  - DECODE on 0010011 → EXECUTEI.
  - DECODE on 1100011 → BEQ.
  - DECODE on any other opcode → see Configuration.
  - MEMADR → MEMREAD for lw, → MEMWRITE for sw.
  - MEMREAD → MEMWB.
  - EXECUTER and EXECUTEI → ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BEQ → FETCH.
- `PCWrite` = (Branch & Zero) | PCUpdate.
- `ImmSrc` is decoded from `op` in every state:
  - 0000011 and 0010011 → 00.
  - 0100011 → 01.
  - 1100011 → 10.
  - All other opcodes → 00.
- ALU decode:
  - ALUOp=add → 000.
  - ALUOp=sub → 001.
  - ALUOp=funct, by funct3:
    - 000 → 001 if (op[5] & funct7b5), else 000.
    - 010 → 101.
    - 110 → 011.
    - 111 → 010.
    - Any other funct3 → 000.

## Timing
- Reset: the state register loads FETCH on the first rising edge with `reset`=1.
- While `reset` is high:
  - PCWrite, IRWrite, RegWrite and MemWrite are forced to 0.
  - IllegalInstr is cleared to 0.
  - All selects take their FETCH values.
- Reset asserted mid-instruction aborts that instruction. Nothing further is written, and the next instruction starts with FETCH in the cycle after `reset` falls.
- Cycle counts from FETCH through the last state:
  - lw: 5 cycles.
  - sw: 4 cycles.
  - R-type and I-type: 4 cycles.
  - beq: 3 cycles.
- `op`, `funct3` and `funct7b5` are sampled from DECODE onward and must stay stable until the next FETCH. The IR is written only in FETCH.
- `Zero` is used only in BEQ. A taken branch writes PC (the ALUOut target) at the end of BEQ.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined:
  - An undefined opcode in DECODE moves to state HALT.
  - HALT drives all enables to 0, holds `IllegalInstr`=1, and stays in HALT until reset.
- `CTRL_ILLEGAL_TRAP_EN` undefined:
  - An undefined opcode in DECODE returns to FETCH with no side effects, i.e. it executes as a 2-cycle NOP.
  - `IllegalInstr` is tied to 0 and HALT is not present.

## Test plan
- Reset held 2 cycles, then released → first cycle shows IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10; the cycle after shows DECODE outputs.
- op=0000011 → state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; ImmSrc=00; RegWrite=1 only in cycle 5 with ResultSrc=01.
- op=0100011 → MemWrite=1 only in cycle 4 with AdrSrc=1; ImmSrc=01; RegWrite never 1.
- op=0110011, funct3=000, funct7b5=1 → ALUControl=001 in EXECUTER. The same op with funct3=111 → 010. Both cases: RegWrite=1 in ALUWB.
- op=1100011 → ImmSrc=10. Zero=1 in BEQ gives PCWrite=1 in cycle 3; Zero=0 gives PCWrite=0 in cycle 3.
- op=1111111:
  - With the macro: IllegalInstr=1 from cycle 3 and held for 10 cycles, all enables 0; reset clears it.
  - Without the macro: next FETCH occurs in cycle 3.
